umul_share_ctrl: RTL and testbench
==================================

// Module: umul_share_ctrl
// PURPOSE
//  Round-robin scheduler that shares one uMUL unary multiplier (and its Sobol RNG) among NREQ requesters.
//  Each requester submits a binary operand pair (A, B) and receives the number of 1s produced on oC.
//  Per job, the block grants one requester, loads B into the multiplier, and streams A as a counter-based
//  unary bitstream on iA. It counts the oC ones and returns the count tagged with the requester id.
// PARAMETERS
//  DATAWD   8  operand width; a stream is 2**DATAWD cycles long
//  NREQ     4  number of requesters (>=2)
//  IDWD     2  width of the response id, = $clog2(NREQ)
// PORTS
//  clk         in   1             clock
//  rst_n       in   1             asynchronous reset, active-low
//  req_valid   in   NREQ          requester i has a job pending
//  req_ready   out  NREQ          one-hot; requester i's job accepted this cycle
//  req_a       in   NREQ*DATAWD   operand A of requester i, in slice [i*DATAWD +: DATAWD]
//  req_b       in   NREQ*DATAWD   operand B of requester i, in slice [i*DATAWD +: DATAWD]
//  rsp_valid   out  1             result available
//  rsp_ready   in   1             consumer accepts the result
//  rsp_id      out  IDWD          requester index of the result
//  rsp_data    out  DATAWD+1      count of oC ones (range 0..2**DATAWD)
//  mul_iA      out  1             unary A bit to the multiplier
//  mul_iB      out  DATAWD        B value to the multiplier
//  mul_loadB   out  1             multiplier B-register load strobe
//  mul_oC      in   1             multiplier product bit; combinational from mul_iA and the loaded B
//  busy        out  1             FSM not in IDLE
// BEHAVIOUR
//  FSM states and transitions:
//   IDLE -> LOAD when any req_valid is high.
//   LOAD -> RUN after exactly 1 cycle.
//   RUN -> DONE when run_cnt == 2**DATAWD-1.
//   DONE -> IDLE on rsp_ready.
//  IDLE:
//   - Round-robin pick among req_valid, searching from ptr upward with wrap.
//   - req_ready[g] is high for one cycle on the granted index only.
//   - A and B are latched on that edge, and ptr <= g+1 (mod NREQ).
//   - No other requester's req_ready rises until the next IDLE.
//  LOAD: mul_loadB=1 and mul_iB=B_lat for one cycle; run_cnt <= 0; acc <= 0.
//  RUN:
//   - mul_iA = (run_cnt < A_lat).
//   - acc += mul_oC in the same cycle; run_cnt increments each cycle.
//   - RUN always lasts exactly 2**DATAWD cycles.
//  DONE:
//   - rsp_valid=1; rsp_data=acc; rsp_id=granted index.
//   - Outputs hold stable until rsp_ready. A rsp_ready low in DONE stalls indefinitely.
//  Latency, grant edge to rsp_valid: 1 + 2**DATAWD cycles (LOAD + RUN).
//  Outputs outside their state: mul_iA=0, mul_loadB=0.
//   - mul_iB holds B_lat while not in IDLE and is 0 in IDLE.
//  Arithmetic: acc is DATAWD+1 bits and never wraps (max 2**DATAWD-1 ones, because A <= 2**DATAWD-1).
//  Boundary conditions:
//   - A=0: iA stays 0 for the whole run, so rsp_data=0.
//   - B=0: the multiplier yields no ones, so rsp_data=0.
//   - rsp_ready in DONE and req_valid in the same cycle: go to IDLE first; arbitration happens next cycle.
//   - A requester dropping req_valid before grant is simply skipped (no latching of stale data).
//   - The multiplier's RNG is not reset between jobs; results depend on its state. No correction is applied.
//  Reset, at any time including mid-RUN:
//   - State=IDLE; ptr=0; acc=0; run_cnt=0; A_lat=0; B_lat=0.
//   - All outputs 0. Any in-flight job is discarded with no response.
//  busy=0 only in IDLE.
// CONFIGURATION
//  UMUL_SHARE_CTRL_EARLY_TERM_EN:
//   - Defined: RUN -> DONE when run_cnt == A_lat-1, or directly after LOAD when A_lat==0.
//     RUN then lasts max(A_lat,0) cycles; latency is 1 + A_lat.
//     Results are identical, because iA=0 after A_lat cycles gives no more ones.
//   - Undefined: fixed 2**DATAWD-cycle RUN, which gives data-independent timing.
// TESTING
//  Bench stub multiplier: oC = iA & (B_loaded > k), where k counts cycles with iA=1 since load. Use DATAWD=8, NREQ=4.
//  1. Req0 A=100 B=60, rsp_ready=1 -> req_ready[0] one cycle; rsp_valid 257 cycles later; data=60, id=0.
//  2. Req2 A=0 B=200 -> rsp_data=0. Req1 A=255 B=0 -> rsp_data=0.
//  3. All four valid continuously, ptr=0 -> grant order 0,1,2,3,0. Exactly one req_ready bit per job.
//  4. rsp_ready held low 10 cycles in DONE -> rsp_valid, data and id stable. No new grant until accept.
//  5. rst_n low mid-RUN (cycle 50) -> next cycle all outputs 0, busy=0. Post-reset, req3 A=10 B=5 -> data=5.
//  6. With EARLY_TERM_EN, A=20 B=255 -> rsp_valid 21 cycles after grant, data=20.
//     A=0 -> rsp_valid 1 cycle after LOAD, data=0.

Source files
------------

// File: rtl/umul_share_ctrl.sv
// -----------------------------------------------------------------------------
// umul_share_ctrl
//   Round-robin scheduler sharing one unary multiplier (uMUL) among NREQ
//   requesters. Each job: grant one requester, load its B operand into the
//   multiplier, stream A as a counter-based unary bitstream on mul_iA, count
//   the ones returned on mul_oC and return the count tagged with the
//   requester id.
//
//   Optional feature macro: UMUL_SHARE_CTRL_EARLY_TERM_EN
//     undefined (default) : RUN always lasts 2**DATAWD cycles, so job timing
//                           does not depend on the operand values.
//     defined             : RUN stops after A cycles (LOAD goes straight to
//                           DONE when A == 0). Results are unchanged because
//                           mul_iA is 0 for the remainder of the stream.
// -----------------------------------------------------------------------------
module umul_share_ctrl #(
    parameter int unsigned DATAWD = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDWD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATAWD-1:0] req_a,
    input  logic [NREQ*DATAWD-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDWD-1:0]        rsp_id,
    output logic [DATAWD:0]        rsp_data,
    output logic                   mul_iA,
    output logic [DATAWD-1:0]      mul_iB,
    output logic                   mul_loadB,
    input  logic                   mul_oC,
    output logic                   busy
);

    localparam int unsigned ACCWD = DATAWD + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    // Next index after v, wrapping at NREQ (works for non-power-of-two NREQ).
    function automatic logic [IDWD-1:0] wrap_inc(input logic [IDWD-1:0] v);
        return (v == IDWD'(NREQ - 1)) ? '0 : v + IDWD'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [IDWD-1:0]    ptr_q,       ptr_d;
    logic [IDWD-1:0]    id_lat_q,    id_lat_d;
    logic [DATAWD-1:0]  a_lat_q,     a_lat_d;
    logic [DATAWD-1:0]  b_lat_q,     b_lat_d;
    logic [DATAWD-1:0]  run_cnt_q,   run_cnt_d;
    logic [ACCWD-1:0]   acc_q,       acc_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [IDWD-1:0]    rsp_id_q,    rsp_id_d;
    logic [ACCWD-1:0]   rsp_data_q,  rsp_data_d;
    logic               mul_ia_q,    mul_ia_d;
    logic [DATAWD-1:0]  mul_ib_q,    mul_ib_d;
    logic               mul_loadb_q, mul_loadb_d;
    logic               busy_q,      busy_d;

    // Arbitration results
    logic               gnt_found;
    logic [IDWD-1:0]    gnt_idx;
    logic [NREQ-1:0]    gnt_oh;
    logic [IDWD-1:0]    cand;
    logic [DATAWD-1:0]  a_sel;
    logic [DATAWD-1:0]  b_sel;
    logic               run_last;

    // Round-robin search: first valid requester at or after ptr, with wrap.
    // NOTE: every signal assigned in always_comb gets a default at the top,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        cand      = ptr_q;
        for (int off = 0; off < NREQ; off++) begin
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
        if (gnt_found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Select the granted requester's operands with constant slice offsets.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDWD'(i)) begin
                a_sel = req_a[i*DATAWD +: DATAWD];
                b_sel = req_b[i*DATAWD +: DATAWD];
            end
        end
    end

    // Accept handshake: only in IDLE and never while reset is asserted, so
    // no requester sees a grant during reset even with req_valid held high.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE)) begin
            req_ready = gnt_oh;
        end
    end

    // Last RUN cycle: full-length stream, or A cycles with early termination.
    always_comb begin
`ifdef UMUL_SHARE_CTRL_EARLY_TERM_EN
        run_last = (run_cnt_q == (a_lat_q - DATAWD'(1)));
`else
        run_last = (run_cnt_q == '1);
`endif
    end

    // FSM next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_lat_d  = id_lat_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        run_cnt_d = run_cnt_q;
        acc_d     = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    state_d  = ST_LOAD;
                    ptr_d    = wrap_inc(gnt_idx);
                    id_lat_d = gnt_idx;
                    a_lat_d  = a_sel;
                    b_lat_d  = b_sel;
                end
            end
            ST_LOAD: begin
                run_cnt_d = '0;
                acc_d     = '0;
`ifdef UMUL_SHARE_CTRL_EARLY_TERM_EN
                state_d   = (a_lat_q == '0) ? ST_DONE : ST_RUN;
`else
                state_d   = ST_RUN;
`endif
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + DATAWD'(1);
                // acc cannot wrap: A <= 2**DATAWD-1 bounds the ones count.
                acc_d     = acc_q + ACCWD'(mul_oC);
                if (run_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the
    // ports come straight from flops.
    always_comb begin
        rsp_valid_d = (state_d == ST_DONE);
        rsp_data_d  = rsp_valid_d ? acc_d : '0;
        rsp_id_d    = rsp_valid_d ? id_lat_d : '0;
        mul_loadb_d = (state_d == ST_LOAD);
        mul_ib_d    = (state_d != ST_IDLE) ? b_lat_d : '0;
        mul_ia_d    = (state_d == ST_RUN) && (run_cnt_d < a_lat_d);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any in-flight job.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    // NOTE: every register here is reset, including the operand latches, so
    // a reset mid-job leaves no stale operand visible on mul_iB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_lat_q    <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            run_cnt_q   <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            mul_ia_q    <= 1'b0;
            mul_ib_q    <= '0;
            mul_loadb_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_lat_q    <= id_lat_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            run_cnt_q   <= run_cnt_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            mul_ia_q    <= mul_ia_d;
            mul_ib_q    <= mul_ib_d;
            mul_loadb_q <= mul_loadb_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign mul_iA    = mul_ia_q;
    assign mul_iB    = mul_ib_q;
    assign mul_loadB = mul_loadb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_umul_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_umul_share_ctrl
//   Directed bench for umul_share_ctrl (DATAWD=8, NREQ=4). A stub multiplier
//   produces oC = iA & (B_loaded > k), k = iA-high cycles since load, so a
//   job's expected count is min(A, B). Build with UMUL_SHARE_CTRL_EARLY_TERM_EN
//   defined to exercise the early-termination timing.
// -----------------------------------------------------------------------------
module tb_umul_share_ctrl;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW:0]     rsp_data;
    logic            mul_iA;
    logic [DW-1:0]   mul_iB;
    logic            mul_loadB;
    logic            mul_oC;
    logic            busy;

    logic [DW-1:0]   a_arr [NR];
    logic [DW-1:0]   b_arr [NR];

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int extra;
    int bad;

    logic [IW-1:0]   order   [5];
    logic [DW:0]     exp_rr  [5];

    umul_share_ctrl #(.DATAWD(DW), .NREQ(NR), .IDWD(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .mul_iA    (mul_iA),
        .mul_iB    (mul_iB),
        .mul_loadB (mul_loadB),
        .mul_oC    (mul_oC),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a_arr[i];
            req_b[i*DW +: DW] = b_arr[i];
        end
    end

    // Stub multiplier: B register plus count of iA-high cycles since load.
    logic [DW-1:0] stub_b = '0;
    logic [DW:0]   stub_k = '0;
    always_ff @(posedge clk) begin
        if (mul_loadB) begin
            stub_b <= mul_iB;
            stub_k <= '0;
        end else if (mul_iA) begin
            stub_k <= stub_k + 9'd1;
        end
    end
    assign mul_oC = mul_iA & ({1'b0, stub_b} > stub_k);

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Grant edge to rsp_valid, in cycles.
    function automatic int exp_lat(input logic [DW-1:0] a);
`ifdef UMUL_SHARE_CTRL_EARLY_TERM_EN
        return 1 + int'(a);
`else
        return 1 + (1 << DW) + 0 * int'(a);
`endif
    endfunction

    // One complete job with rsp_ready high; DUT must be idle on entry.
    task automatic run_job(input logic [IW-1:0] idx, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW:0] exp_data,
                           input string tag);
        int cyc;
        int ia_cnt;
        a_arr[idx]     = a;
        b_arr[idx]     = b;
        req_valid[idx] = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
        tick();
        req_valid[idx] = 1'b0;
        check({tag, "_load"}, 32'({busy, mul_loadB, mul_iB}), 32'({1'b1, 1'b1, b}));
        cyc    = 0;
        ia_cnt = 0;
        while (!rsp_valid && cyc < 600) begin
            tick();
            cyc++;
            if (mul_iA) ia_cnt++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(a)));
        check({tag, "_ia_ones"}, 32'(ia_cnt), 32'(a));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_id"}, 32'(rsp_id), 32'(idx));
        tick();
        check({tag, "_back_idle"}, 32'({rsp_valid, busy}), 32'(0));
    endtask

    initial begin
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end

        // Reset state
        tick();
        tick();
        check("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, mul_iA, mul_iB, mul_loadB, busy}), 32'(0));
        rst_n = 1'b1;
        tick();
        check("reset_released_idle", 32'({busy, rsp_valid}), 32'(0));

        // 1. Basic job on requester 0
        run_job(2'd0, 8'd100, 8'd60, 9'd60, "t1");

        // 2. Zero operands
        run_job(2'd2, 8'd0, 8'd200, 9'd0, "t2_a0");
        run_job(2'd1, 8'd255, 8'd0, 9'd0, "t2_b0");

        // 3. Round robin with all four valid, starting from ptr=0
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        a_arr = '{8'd10, 8'd20, 8'd5, 8'd255};
        b_arr = '{8'd3, 8'd30, 8'd5, 8'd255};
        order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_rr = '{9'd3, 9'd20, 9'd5, 9'd255, 9'd3};
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            #1;
            n = 0;
            while (req_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            check("rr_grant", 32'(req_ready), 32'(4'b0001 << order[j]));
            tick();
            if (j == 4) req_valid = '0;
            extra = 0;
            n = 0;
            while (!rsp_valid && n < 600) begin
                if (req_ready != '0) extra++;
                tick();
                n++;
            end
            check("rr_no_extra_ready", 32'(extra + (req_ready != '0 ? 1 : 0)), 32'(0));
            check("rr_id", 32'(rsp_id), 32'(order[j]));
            check("rr_data", 32'(rsp_data), 32'(exp_rr[j]));
            tick();
        end

        // 4. Response stall with another requester waiting
        rsp_ready = 1'b0;
        a_arr[1]  = 8'd7;
        b_arr[1]  = 8'd9;
        req_valid = 4'b0010;
        #1;
        check("stall_grant", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = 4'b0001;
        n = 0;
        while (!rsp_valid && n < 600) begin
            tick();
            n++;
        end
        check("stall_latency", 32'(n), 32'(exp_lat(8'd7)));
        check("stall_data", 32'(rsp_data), 32'(7));
        check("stall_id", 32'(rsp_id), 32'(1));
        bad = 0;
        repeat (10) begin
            tick();
            if (!rsp_valid || rsp_data !== 9'd7 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || !busy) bad++;
        end
        check("stall_stable", 32'(bad), 32'(0));
        rsp_ready = 1'b1;
        tick();
        check("stall_accept_idle", 32'({rsp_valid, busy}), 32'(0));
        check("stall_next_grant", 32'(req_ready), 32'(4'b0001));
        req_valid = '0;
        #1;
        check("drop_valid_skipped", 32'(req_ready), 32'(0));
        tick();
        check("drop_valid_stays_idle", 32'(busy), 32'(0));

        // 5. Reset in the middle of RUN
        a_arr[2]  = 8'd200;
        b_arr[2]  = 8'd100;
        req_valid = 4'b0100;
        #1;
        check("rst_grant", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = '0;
        repeat (50) tick();
        check("rst_midrun", 32'({busy, mul_iA}), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        check("rst_async_zero", 32'({req_ready, rsp_valid, rsp_id, rsp_data, mul_iA, mul_iB, mul_loadB, busy}), 32'(0));
        tick();
        check("rst_held_zero", 32'({req_ready, rsp_valid, rsp_id, rsp_data, mul_iA, mul_iB, mul_loadB, busy}), 32'(0));
        rst_n = 1'b1;
        tick();
        check("rst_no_response", 32'({rsp_valid, busy}), 32'(0));
        req_valid = 4'b1010;
        #1;
        check("rst_ptr_cleared", 32'(req_ready), 32'(4'b0010));
        req_valid = 4'b1000;
        run_job(2'd3, 8'd10, 8'd5, 9'd5, "rst_job");

`ifdef UMUL_SHARE_CTRL_EARLY_TERM_EN
        // 6. Early termination timing
        run_job(2'd0, 8'd20, 8'd255, 9'd20, "et_a20");
        run_job(2'd1, 8'd0, 8'd77, 9'd0, "et_a0");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
